// File: rtl/gate_sweep_checker.sv
// rtl/gate_sweep_checker.sv - sweeps a two-input gate through all vectors and checks it
// against a selected reference function, reporting error count, fail mask and pass.
module gate_sweep_checker #(
    parameter int HOLD_CYCLES = 4,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op_sel,
    input  logic             y_in,
    output logic             a_out,
    output logic             b_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_vec
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t           r_state;
    logic [1:0]       r_idx;
    logic [CNT_W-1:0] r_hold;
    logic [2:0]       r_op;
    logic             r_a;
    logic             r_b;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [ERR_W-1:0] r_err;
    logic [3:0]       r_fail;

    state_t           w_state_nxt;
    logic [1:0]       w_idx_nxt;
    logic [CNT_W-1:0] w_hold_nxt;
    logic [2:0]       w_op_nxt;
    logic             w_a_nxt;
    logic             w_b_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_pass_nxt;
    logic [ERR_W-1:0] w_err_nxt;
    logic [3:0]       w_fail_nxt;
    logic             w_sample;
    logic             w_expected;

    function automatic logic ref_fn(input logic [2:0] op, input logic a, input logic b);
        case (op)
            3'b000:  ref_fn = a & b;
            3'b001:  ref_fn = a | b;
            3'b010:  ref_fn = a ^ b;
            3'b011:  ref_fn = ~(a & b);
            3'b100:  ref_fn = ~(a | b);
            3'b101:  ref_fn = ~(a ^ b);
            3'b110:  ref_fn = ~a;
            default: ref_fn = a;
        endcase
    endfunction

    assign w_sample   = (r_hold == CNT_W'(HOLD_CYCLES - 1));
    assign w_expected = ref_fn(r_op, r_a, r_b);

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_hold_nxt  = r_hold;
        w_op_nxt    = r_op;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_pass_nxt  = r_pass;
        w_err_nxt   = r_err;
        w_fail_nxt  = r_fail;
        case (r_state)
            S_IDLE: begin
                w_a_nxt = 1'b0;
                w_b_nxt = 1'b0;
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_idx_nxt   = 2'd0;
                    w_hold_nxt  = '0;
                    w_op_nxt    = op_sel;
                    w_busy_nxt  = 1'b1;
                    w_pass_nxt  = 1'b0;
                    w_err_nxt   = '0;
                    w_fail_nxt  = 4'b0000;
                end
            end
            S_RUN: begin
                if (w_sample) begin
                    // Only the last hold cycle counts, so a slow gate may settle freely.
                    if (y_in != w_expected) begin
                        w_fail_nxt[r_idx] = 1'b1;
                        if (r_err != {ERR_W{1'b1}}) begin
                            w_err_nxt = r_err + ERR_W'(1);
                        end
                    end
                    w_hold_nxt = '0;
                    if (r_idx == 2'd3) begin
                        w_state_nxt = S_FINISH;
                        w_busy_nxt  = 1'b0;
                        w_a_nxt     = 1'b0;
                        w_b_nxt     = 1'b0;
                    end else begin
                        w_idx_nxt = r_idx + 2'd1;
                        w_a_nxt   = w_idx_nxt[1];
                        w_b_nxt   = w_idx_nxt[0];
                    end
                end else begin
                    w_hold_nxt = r_hold + CNT_W'(1);
                end
            end
            S_FINISH: begin
                w_done_nxt  = 1'b1;
                w_pass_nxt  = (r_err == '0);
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
            r_hold  <= '0;
            r_op    <= 3'b000;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_fail  <= 4'b0000;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_hold  <= w_hold_nxt;
            r_op    <= w_op_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_pass  <= w_pass_nxt;
            r_err   <= w_err_nxt;
            r_fail  <= w_fail_nxt;
        end
    end

    assign a_out     = r_a;
    assign b_out     = r_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_vec  = r_fail;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb/tb_gate_sweep_checker.sv - scoreboard bench for gate_sweep_checker, driving a
// modelled gate under test per scenario.
module tb_gate_sweep_checker;

    typedef struct packed {
        logic       pass;
        logic [7:0] err;
        logic [3:0] fail;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op_sel = 3'b000;
    logic       y_in;
    logic       a_out, b_out, busy, done, pass;
    logic [7:0] err_count;
    logic [3:0] fail_vec;

    logic       start2 = 1'b0;
    logic [2:0] op_sel2 = 3'b010;
    logic       y2;
    logic       a2, b2, busy2, done2, pass2;
    logic [0:0] err2;
    logic [3:0] fail2;

    int   mode = 0;
    logic [1:0] hc = 2'd0;
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    gate_sweep_checker #(.HOLD_CYCLES(4), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_sel(op_sel), .y_in(y_in),
        .a_out(a_out), .b_out(b_out), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_vec(fail_vec)
    );

    gate_sweep_checker #(.HOLD_CYCLES(1), .ERR_W(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .op_sel(op_sel2), .y_in(y2),
        .a_out(a2), .b_out(b2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .fail_vec(fail2)
    );

    // Position within the current held vector; hc==3 is the sampling cycle.
    always @(posedge clk) begin
        if (!busy) hc <= 2'd0;
        else       hc <= hc + 2'd1;
    end

    always_comb begin
        y_in = 1'b0;
        case (mode)
            0: y_in = a_out & b_out;
            1: y_in = a_out | b_out;
            2: y_in = 1'b0;
            3: y_in = (hc == 2'd3) ? (a_out & b_out) : ~(a_out & b_out);
            4: y_in = a_out ^ b_out;
            default: y_in = 1'b0;
        endcase
    end

    always_comb begin
        y2 = ~(a2 ^ b2);
    end

    function automatic logic ref_fn(input logic [2:0] op, input logic a, input logic b);
        case (op)
            3'b000: return a & b;
            3'b001: return a | b;
            3'b010: return a ^ b;
            3'b011: return ~(a & b);
            3'b100: return ~(a | b);
            3'b101: return ~(a ^ b);
            3'b110: return ~a;
            default: return a;
        endcase
    endfunction

    function automatic logic model_y(input int m, input logic a, input logic b);
        case (m)
            0: return a & b;
            1: return a | b;
            2: return 1'b0;
            3: return a & b;
            4: return a ^ b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic push_exp(input logic [2:0] op, input int m);
        exp_t e;
        logic [1:0] vv;
        e = '0;
        for (int v = 0; v < 4; v++) begin
            vv = 2'(v);
            if (model_y(m, vv[1], vv[0]) != ref_fn(op, vv[1], vv[0])) begin
                e.fail[v] = 1'b1;
                e.err = e.err + 8'd1;
            end
        end
        e.pass = (e.err == 8'd0);
        sb.push_back(e);
    endtask

    task automatic pulse_start(input logic [2:0] op, input int m, input bit push);
        @(negedge clk);
        mode = m;
        op_sel = op;
        start = 1'b1;
        if (push) push_exp(op, m);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int lat, input bit wave, input int inj_n,
                             input bit chain, input logic [2:0] nop, input int nmode);
        int n;
        bit got;
        exp_t e;
        logic [1:0] vi;
        n = 0;
        got = 1'b0;
        while (!got && n <= lat + 4) begin
            if (n == inj_n) begin start = 1'b1; op_sel = 3'b001; end
            if (n == inj_n + 1) start = 1'b0;
            if (wave && n <= 16) begin
                vi = 2'(n / 4);
                checks++;
                if (busy !== (n < 16)) begin
                    errors++; $display("FAIL busy n=%0d got=%b want=%b", n, busy, (n < 16));
                end
                checks++;
                if ({a_out, b_out} !== ((n < 16) ? vi : 2'b00)) begin
                    errors++; $display("FAIL vector n=%0d got=%b%b want=%b", n, a_out, b_out, (n < 16) ? vi : 2'b00);
                end
            end
            if (done === 1'b1) begin
                got = 1'b1;
                checks++;
                if (n != lat) begin
                    errors++; $display("FAIL done_latency got=%0d want=%0d", n, lat);
                end
                if (sb.size() == 0) begin
                    checks++; errors++; $display("FAIL scoreboard_empty at done");
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (pass !== e.pass || err_count !== e.err || fail_vec !== e.fail) begin
                        errors++;
                        $display("FAIL result got pass=%b err=%0d fail=%b want pass=%b err=%0d fail=%b",
                                 pass, err_count, fail_vec, e.pass, e.err, e.fail);
                    end
                end
                if (chain) begin
                    mode = nmode;
                    op_sel = nop;
                    start = 1'b1;
                    push_exp(nop, nmode);
                end
            end else begin
                @(negedge clk);
                n++;
            end
        end
        if (!got) begin
            checks++; errors++; $display("FAIL done_timeout got=none want=%0d", lat);
        end else begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (done !== 1'b0) begin
                errors++; $display("FAIL done_pulse got=%b want=0", done);
            end
            if (chain) begin
                checks++;
                if (pass !== 1'b0 || err_count !== 8'd0 || busy !== 1'b1) begin
                    errors++; $display("FAIL chain_clear got pass=%b err=%0d busy=%b want 0 0 1", pass, err_count, busy);
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({a_out, b_out, busy, done, pass, err_count, fail_vec} !== 17'd0 ||
            {a2, b2, busy2, done2, pass2, err2, fail2} !== 10'd0) begin
            errors++;
            $display("FAIL %s got a=%b b=%b busy=%b done=%b pass=%b err=%0d fail=%b want all 0",
                     tag, a_out, b_out, busy, done, pass, err_count, fail_vec);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_state");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_and();
        pulse_start(3'b000, 0, 1'b1);
        wait_done(17, 1'b1, -1, 1'b0, 3'b000, 0);
    endtask

    task automatic test_mismatches();
        pulse_start(3'b000, 1, 1'b1);
        wait_done(17, 1'b0, -1, 1'b0, 3'b000, 0);
        pulse_start(3'b011, 2, 1'b1);
        wait_done(17, 1'b0, -1, 1'b0, 3'b000, 0);
    endtask

    task automatic test_settling();
        pulse_start(3'b000, 3, 1'b1);
        wait_done(17, 1'b0, -1, 1'b0, 3'b000, 0);
    endtask

    task automatic test_back_to_back();
        pulse_start(3'b000, 0, 1'b1);
        wait_done(17, 1'b0, 5, 1'b1, 3'b011, 2);
        wait_done(17, 1'b0, -1, 1'b0, 3'b000, 0);
    endtask

    task automatic test_abort();
        int n;
        bit seen;
        pulse_start(3'b000, 0, 1'b0);
        repeat (9) @(negedge clk);
        checks++;
        if ({a_out, b_out} !== 2'b10) begin
            errors++; $display("FAIL abort_vector got=%b%b want=10", a_out, b_out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort_reset");
        seen = 1'b0;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
            if (n == 2) rst_n = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL abort_done got=1 want=0");
        end
        pulse_start(3'b010, 4, 1'b1);
        wait_done(17, 1'b0, -1, 1'b0, 3'b000, 0);
    endtask

    task automatic test_saturate();
        int n;
        bit got;
        @(negedge clk);
        op_sel2 = 3'b010;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        got = 1'b0;
        while (!got && n < 12) begin
            if (done2 === 1'b1) got = 1'b1;
            else begin @(negedge clk); n++; end
        end
        checks++;
        if (!got || n != 5) begin
            errors++; $display("FAIL sat_latency got=%0d want=5", got ? n : -1);
        end
        checks++;
        if (err2 !== 1'b1 || fail2 !== 4'b1111 || pass2 !== 1'b0) begin
            errors++;
            $display("FAIL sat_result got err=%b fail=%b pass=%b want err=1 fail=1111 pass=0", err2, fail2, pass2);
        end
    endtask

    initial begin
        test_reset();
        test_basic_and();
        test_mismatches();
        test_settling();
        test_back_to_back();
        test_abort();
        test_saturate();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
